// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: walks each instruction through IF/ID/EX/MEM/WB,
// drives the datapath selects and strobes, and halts on illegal opcodes or memory timeouts.
//
// state | meaning
// IF    | fetch request outstanding, waiting for imem_valid
// ID    | decode captured opcode, register the datapath selects
// EX    | execute; branches resolve and retire here
// MEM   | data access outstanding, waiting for dmem_ready
// WB    | register write-back, PC update, retire
// TRAP  | halted until rst, cause held in trap_cause
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        imem_valid,
    input  logic        dmem_ready,
    input  logic        b_taken,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        alu_op1_sel,
    output logic        alu_op2_sel,
    output logic        jb_op1_sel,
    output logic        wb_sel,
    output logic        next_pc_sel,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Wait timer counts down from TIMEOUT-1; terminal count of zero is the last allowed wait cycle.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      opcode_q;
    logic [4:0]      rd_q;
    logic [1:0]      cause_q, cause_d;
    logic            trap_set;
    logic            legal, op1_d, op2_d, jb_d, wb_d;
    logic            is_load, is_store, is_branch, is_jump;
    logic            unused_inst;

    // Only the opcode and rd fields steer sequencing; the rest belongs to the datapath.
    assign unused_inst = ^inst[31:12];

    assign is_load   = (opcode_q == OPC_LOAD);
    assign is_store  = (opcode_q == OPC_STORE);
    assign is_branch = (opcode_q == OPC_BRANCH);
    assign is_jump   = (opcode_q == OPC_JAL) || (opcode_q == OPC_JALR);

    always_comb begin
        legal = 1'b1;
        op1_d = 1'b1;
        op2_d = 1'b0;
        jb_d  = 1'b0;
        wb_d  = 1'b0;
        case (opcode_q)
            OPC_OP:                      op2_d = 1'b1;
            OPC_OP_IMM, OPC_STORE:       op2_d = 1'b0;
            OPC_LOAD:                    wb_d  = 1'b1;
            OPC_LUI, OPC_AUIPC, OPC_JAL: op1_d = 1'b0;
            OPC_JALR: begin
                op1_d = 1'b0;
                jb_d  = 1'b1;
            end
            OPC_BRANCH:                  op2_d = 1'b1;
            default:                     legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IF;
            cnt_q       <= CNT_LOAD;
            opcode_q    <= 7'd0;
            rd_q        <= 5'd0;
            cause_q     <= 2'b00;
            alu_op1_sel <= 1'b1;
            alu_op2_sel <= 1'b1;
            jb_op1_sel  <= 1'b0;
            wb_sel      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ir_we) begin
                opcode_q <= inst[6:0];
                rd_q     <= inst[11:7];
            end
            if (state_q == S_ID && legal) begin
                alu_op1_sel <= op1_d;
                alu_op2_sel <= op2_d;
                jb_op1_sel  <= jb_d;
                wb_sel      <= wb_d;
            end
            if (trap_set) begin
                cause_q <= cause_d;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cause_d     = 2'b00;
        trap_set    = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        reg_we      = 1'b0;
        retire      = 1'b0;
        next_pc_sel = 1'b1;
        case (state_q)
            S_IF: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_we   = 1'b1;
                    state_d = S_ID;
                end else if (cnt_q == '0) begin
                    state_d  = S_TRAP;
                    trap_set = 1'b1;
                    cause_d  = 2'b10;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ID: begin
                if (legal) begin
                    state_d = S_EX;
                end else begin
                    state_d  = S_TRAP;
                    trap_set = 1'b1;
                    cause_d  = 2'b01;
                end
            end
            S_EX: begin
                if (is_branch) begin
                    pc_we       = 1'b1;
                    next_pc_sel = ~b_taken;
                    retire      = 1'b1;
                    state_d     = S_IF;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                end else if (cnt_q == '0) begin
                    state_d  = S_TRAP;
                    trap_set = 1'b1;
                    cause_d  = 2'b11;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WB: begin
                reg_we      = (rd_q != 5'd0);
                pc_we       = 1'b1;
                retire      = 1'b1;
                next_pc_sel = ~is_jump;
                state_d     = S_IF;
            end
            S_TRAP: ;
            default: state_d = S_IF;
        endcase
        // Every state change re-arms the wait timer.
        if (state_d != state_q) begin
            cnt_d = CNT_LOAD;
        end
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a random instruction
// stream, compared per cycle against a timeline model derived from the sequencing rules.
module tb_multicycle_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = 32'd0;
    logic        imem_valid = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        b_taken = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
    logic        alu_op1_sel, alu_op2_sel, jb_op1_sel, wb_sel, next_pc_sel;
    logic        retire, trap;
    logic [1:0]  trap_cause;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] obs [0:63];
    logic [3:0] sel_obs;

    multicycle_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .inst(inst), .imem_valid(imem_valid),
        .dmem_ready(dmem_ready), .b_taken(b_taken), .imem_req(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
        .reg_we(reg_we), .alu_op1_sel(alu_op1_sel), .alu_op2_sel(alu_op2_sel),
        .jb_op1_sel(jb_op1_sel), .wb_sel(wb_sel), .next_pc_sel(next_pc_sel),
        .retire(retire), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int instr_len(input logic [31:0] in, input int iw, input int dw);
        case (in[6:0])
            7'h63:   return iw + 3;
            7'h23:   return iw + 4 + dw;
            7'h03:   return iw + 5 + dw;
            default: return iw + 4;
        endcase
    endfunction

    // {trap, imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retire, next_pc_sel if pc_we}
    function automatic logic [8:0] model_cycle(input logic [31:0] in, input int iw,
                                               input int dw, input logic bt, input int t);
        logic ld, st, br, jmp;
        logic imr, dmr, dwe, irw, pcw, rgw, ret, npc;
        ld  = (in[6:0] == 7'h03);
        st  = (in[6:0] == 7'h23);
        br  = (in[6:0] == 7'h63);
        jmp = (in[6:0] == 7'h6F) || (in[6:0] == 7'h67);
        {imr, dmr, dwe, irw, pcw, rgw, ret, npc} = 8'b0;
        if (t <= iw) begin
            imr = 1'b1;
            irw = (t == iw);
        end else if (br && t == iw + 2) begin
            pcw = 1'b1; ret = 1'b1; npc = ~bt;
        end else if ((ld || st) && t >= iw + 3 && t <= iw + 3 + dw) begin
            dmr = 1'b1;
            dwe = st;
            if (st && t == iw + 3 + dw) begin
                pcw = 1'b1; ret = 1'b1; npc = 1'b1;
            end
        end else if ((!br && !ld && !st && t == iw + 3) || (ld && t == iw + 4 + dw)) begin
            rgw = (in[11:7] != 5'd0);
            pcw = 1'b1; ret = 1'b1; npc = ~jmp;
        end
        return {1'b0, imr, dmr, dwe, irw, pcw, rgw, ret, npc};
    endfunction

    // {alu_op1_sel, alu_op2_sel, jb_op1_sel, wb_sel}
    function automatic logic [3:0] model_sel(input logic [31:0] in);
        case (in[6:0])
            7'h33, 7'h63:        return 4'b1100;
            7'h13, 7'h23:        return 4'b1000;
            7'h03:               return 4'b1001;
            7'h67:               return 4'b0010;
            default:             return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] sel_mask(input logic [31:0] in);
        return (in[6:0] == 7'h6F || in[6:0] == 7'h67 || in[6:0] == 7'h63) ? 4'b1111 : 4'b1101;
    endfunction

    // ---------------- stimulus ----------------
    task automatic do_reset();
        rst = 1'b1; imem_valid = 1'b0; dmem_ready = 1'b0; b_taken = 1'b0; inst = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Drives one instruction starting in its first IF cycle and records outputs per cycle.
    task automatic run_instr(input logic [31:0] in, input int iw, input int dw, input logic bt);
        int  len;
        logic is_mem;
        len    = instr_len(in, iw, dw);
        is_mem = (in[6:0] == 7'h03) || (in[6:0] == 7'h23);
        for (int t = 0; t < len; t++) begin
            imem_valid = (t == iw) ? 1'b1 : ((t < iw) ? 1'b0 : 1'($urandom));
            inst       = (t == iw) ? in : 32'($urandom);
            dmem_ready = (is_mem && t >= iw + 3) ? (t == iw + 3 + dw) : 1'($urandom);
            b_taken    = (t == iw + 2) ? bt : 1'($urandom);
            @(negedge clk);
            obs[t]  = {trap, imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retire,
                       pc_we & next_pc_sel};
            sel_obs = {alu_op1_sel, alu_op2_sel, jb_op1_sel, wb_sel};
            @(posedge clk); #1;
        end
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; imem_valid = 1'b0; dmem_ready = 1'($urandom); b_taken = 1'($urandom);
        inst = 32'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retire, trap, trap_cause}
            !== 10'b1000000000) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want %b",
                     {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retire, trap, trap_cause},
                     10'b1000000000);
        end
        vectors++;
        if ({alu_op1_sel, alu_op2_sel, jb_op1_sel, wb_sel, next_pc_sel} !== 5'b11001) begin
            miscompares++;
            $display("FAIL reset_selects: got %b want %b",
                     {alu_op1_sel, alu_op2_sel, jb_op1_sel, wb_sel, next_pc_sel}, 5'b11001);
        end
        do_reset();
    endtask

    task automatic test_directed();
        logic [31:0] ins [5];
        int          dws [5];
        logic        bts [5];
        int          len;
        // ADD x3,x1,x2 ; BEQ taken ; BEQ not taken ; LW x5 with 3 wait cycles ; JALR x0
        ins = '{32'h002081B3, 32'h00208463, 32'h00208463, 32'h0000A283, 32'h00008067};
        dws = '{0, 0, 0, 3, 0};
        bts = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_instr(ins[k], 0, dws[k], bts[k]);
            len = instr_len(ins[k], 0, dws[k]);
            for (int t = 0; t < len; t++) begin
                vectors++;
                if (obs[t] !== model_cycle(ins[k], 0, dws[k], bts[k], t)) begin
                    miscompares++;
                    $display("FAIL directed%0d cycle %0d: got %b want %b", k, t, obs[t],
                             model_cycle(ins[k], 0, dws[k], bts[k], t));
                end
            end
            vectors++;
            if ((sel_obs & sel_mask(ins[k])) !== (model_sel(ins[k]) & sel_mask(ins[k]))) begin
                miscompares++;
                $display("FAIL directed%0d selects: got %b want %b", k, sel_obs,
                         model_sel(ins[k]));
            end
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [10];
        logic [31:0] r, in;
        int          iw, dw, len;
        logic        bt;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03};
        do_reset();
        for (int n = 0; n < 150; n++) begin
            r  = $urandom;
            in = {r[31:7], ops[$urandom_range(0, 9)]};
            iw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            bt = 1'($urandom);
            run_instr(in, iw, dw, bt);
            len = instr_len(in, iw, dw);
            for (int t = 0; t < len; t++) begin
                vectors++;
                if (obs[t] !== model_cycle(in, iw, dw, bt, t)) begin
                    miscompares++;
                    $display("FAIL random inst %h cycle %0d: got %b want %b", in, t, obs[t],
                             model_cycle(in, iw, dw, bt, t));
                end
            end
            vectors++;
            if ((sel_obs & sel_mask(in)) !== (model_sel(in) & sel_mask(in))) begin
                miscompares++;
                $display("FAIL random selects inst %h: got %b want %b", in, sel_obs,
                         model_sel(in));
            end
        end
    endtask

    // Handshakes landing on the final allowed wait cycle must complete without trapping.
    task automatic test_valid_wins();
        logic [31:0] in;
        int          len;
        in = 32'h0020A423;   // SW x2,8(x1)
        do_reset();
        run_instr(in, TO - 1, TO - 1, 1'b0);
        len = instr_len(in, TO - 1, TO - 1);
        for (int t = 0; t < len; t++) begin
            vectors++;
            if (obs[t] !== model_cycle(in, TO - 1, TO - 1, 1'b0, t)) begin
                miscompares++;
                $display("FAIL valid_wins cycle %0d: got %b want %b", t, obs[t],
                         model_cycle(in, TO - 1, TO - 1, 1'b0, t));
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        imem_valid = 1'b1; inst = 32'h0000007F;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            imem_valid = 1'($urandom); dmem_ready = 1'($urandom); inst = 32'($urandom);
            @(negedge clk);
            vectors++;
            if ({trap, trap_cause, imem_req, dmem_req, ir_we, pc_we, reg_we, retire}
                !== 9'b101000000) begin
                miscompares++;
                $display("FAIL illegal_trap cycle %0d: got %b want %b", c,
                         {trap, trap_cause, imem_req, dmem_req, ir_we, pc_we, reg_we, retire},
                         9'b101000000);
            end
            @(posedge clk); #1;
        end
        do_reset();
        @(negedge clk);
        vectors++;
        if ({trap, trap_cause, imem_req} !== 4'b0001) begin
            miscompares++;
            $display("FAIL illegal_release: got %b want %b", {trap, trap_cause, imem_req}, 4'b0001);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_imem_timeout();
        do_reset();
        imem_valid = 1'b0;
        for (int c = 0; c < TO; c++) begin
            inst = 32'($urandom);
            @(negedge clk);
            vectors++;
            if ({trap, imem_req} !== 2'b01) begin
                miscompares++;
                $display("FAIL imem_wait cycle %0d: got %b want %b", c, {trap, imem_req}, 2'b01);
            end
            @(posedge clk); #1;
        end
        for (int c = 0; c < 4; c++) begin
            imem_valid = 1'($urandom);
            @(negedge clk);
            vectors++;
            if ({trap, trap_cause, imem_req, dmem_req} !== 5'b11000) begin
                miscompares++;
                $display("FAIL imem_timeout cycle %0d: got %b want %b", c,
                         {trap, trap_cause, imem_req, dmem_req}, 5'b11000);
            end
            @(posedge clk); #1;
        end
        do_reset();
        @(negedge clk);
        vectors++;
        if ({trap, trap_cause, imem_req} !== 4'b0001) begin
            miscompares++;
            $display("FAIL imem_timeout_release: got %b want %b", {trap, trap_cause, imem_req},
                     4'b0001);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_dmem_timeout();
        int req_cycles;
        req_cycles = 0;
        do_reset();
        imem_valid = 1'b1; inst = 32'h0000A283;
        @(posedge clk); #1;
        imem_valid = 1'b0; dmem_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        for (int c = 0; c < TO + 4; c++) begin
            @(negedge clk);
            if (dmem_req) req_cycles++;
            @(posedge clk); #1;
        end
        vectors++;
        if (req_cycles != TO) begin
            miscompares++;
            $display("FAIL dmem_wait_cycles: got %0d want %0d", req_cycles, TO);
        end
        @(negedge clk);
        vectors++;
        if ({trap, trap_cause, dmem_req, imem_req} !== 5'b11100) begin
            miscompares++;
            $display("FAIL dmem_timeout: got %b want %b", {trap, trap_cause, dmem_req, imem_req},
                     5'b11100);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid_mem();
        do_reset();
        imem_valid = 1'b1; inst = 32'h0000A283;
        @(posedge clk); #1;
        imem_valid = 1'b0; dmem_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        vectors++;
        if ({dmem_req, imem_req, alu_op2_sel, wb_sel} !== 4'b1001) begin
            miscompares++;
            $display("FAIL mid_mem_state: got %b want %b",
                     {dmem_req, imem_req, alu_op2_sel, wb_sel}, 4'b1001);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({dmem_req, imem_req, alu_op1_sel, alu_op2_sel, jb_op1_sel, wb_sel, next_pc_sel}
            !== 7'b0111001) begin
            miscompares++;
            $display("FAIL rst_mid_mem: got %b want %b",
                     {dmem_req, imem_req, alu_op1_sel, alu_op2_sel, jb_op1_sel, wb_sel,
                      next_pc_sel}, 7'b0111001);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_valid_wins();
        test_illegal();
        test_imem_timeout();
        test_dmem_timeout();
        test_rst_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
